mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl_if.sv | 46 ++++
 rtl/mem_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the byte-serial memory controller:
// FSM encoding, length codes, RAM strobe values and bus widths.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    localparam logic [2:0] LEN_1 = 3'd1;
    localparam logic [2:0] LEN_2 = 3'd2;
    localparam logic [2:0] LEN_4 = 3'd4;

    localparam logic RAM_WRITE = 1'b1;
    localparam logic RAM_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_t;

    // Any length code other than 1 or 2 moves a full word.
    function automatic logic [2:0] len_to_n(input logic [2:0] len);
        case (len)
            LEN_1:   return LEN_1;
            LEN_2:   return LEN_2;
            default: return LEN_4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the fetch port, load/store port and byte-wide RAM port of mem_ctrl,
// plus the FSM state exposed for debug.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    // Handshake: a requester holds req high; the controller samples it only while
    // idle and never in the cycle that port's done is high. done is a one-cycle
    // pulse and the matching data output is valid in that cycle and held after.
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_cancel_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_done_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [2:0]        mem_len_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_done_o;

    logic [BYTE_W-1:0] ram_din_i;
    logic [BYTE_W-1:0] ram_dout_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic              ram_wr_o;

    state_t            dbg_state;

    modport slave (
        input  if_req_i, if_addr_i, if_cancel_i,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_len_i,
        input  ram_din_i,
        output if_data_o, if_done_o, mem_data_o, mem_done_o,
        output ram_dout_o, ram_a_o, ram_wr_o, dbg_state
    );

    modport master (
        output if_req_i, if_addr_i, if_cancel_i,
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_len_i,
        output ram_din_i,
        input  if_data_o, if_done_o, mem_data_o, mem_done_o,
        input  ram_dout_o, ram_a_o, ram_wr_o, dbg_state
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates an instruction-fetch port and a load/store port onto a byte-wide
// RAM with one-cycle read latency, moving 1, 2 or 4 bytes little-endian.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    state_t            state_q, state_nxt;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] if_data_q, mem_data_q;
    logic              if_done_q, mem_done_q;

    logic              accept_mem, accept_if;
    logic              rd_state, rd_last, cancel_now;
    logic [DATA_W-1:0] rd_word;
    logic [1:0]        rd_slot;

    assign rd_state   = (state_q == ST_IF_RD) || (state_q == ST_MEM_RD);
    assign cancel_now = (state_q == ST_IF_RD) && bus.if_cancel_i;
    assign rd_last    = rd_state && !cancel_now && (cnt_q == n_q);
    // Byte arriving now was addressed two edges ago, i.e. byte index cnt-1.
    assign rd_slot    = cnt_q[1:0] - 2'd1;
    assign rd_word    = asm_q | (DATA_W'(bus.ram_din_i) << {n_q - 3'd1, 3'b000});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        accept_mem = 1'b0;
        accept_if  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_req_i && !mem_done_q) begin
                    accept_mem = 1'b1;
                    state_nxt  = bus.mem_we_i ? ST_MEM_WR : ST_MEM_RD;
                end else if (bus.if_req_i && !bus.if_cancel_i && !if_done_q) begin
                    accept_if = 1'b1;
                    state_nxt = ST_IF_RD;
                end
            end
            ST_IF_RD: begin
                if (bus.if_cancel_i || (cnt_q == n_q)) state_nxt = ST_IDLE;
            end
            ST_MEM_RD: begin
                if (cnt_q == n_q) state_nxt = ST_IDLE;
            end
            ST_MEM_WR: begin
                if (cnt_q == n_q - 3'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            n_q        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            if_data_q  <= '0;
            mem_data_q <= '0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;

            if (accept_mem) begin
                addr_q  <= bus.mem_addr_i;
                wdata_q <= bus.mem_wdata_i;
                n_q     <= len_to_n(bus.mem_len_i);
                cnt_q   <= '0;
                asm_q   <= '0;
            end else if (accept_if) begin
                addr_q  <= bus.if_addr_i;
                n_q     <= LEN_4;
                cnt_q   <= '0;
                asm_q   <= '0;
            end else if (state_nxt != ST_IDLE) begin
                cnt_q <= cnt_q + 3'd1;
            end else begin
                cnt_q <= '0;
            end

            if (rd_last) begin
                if (state_q == ST_IF_RD) begin
                    if_data_q <= rd_word;
                    if_done_q <= 1'b1;
                end else begin
                    mem_data_q <= rd_word;
                    mem_done_q <= 1'b1;
                end
            end else if (rd_state && !cancel_now && (cnt_q != 3'd0)) begin
                asm_q[{rd_slot, 3'b000} +: BYTE_W] <= bus.ram_din_i;
            end

            if ((state_q == ST_MEM_WR) && (cnt_q == n_q - 3'd1)) begin
                mem_done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.ram_a_o    = '0;
        bus.ram_wr_o   = RAM_READ;
        bus.ram_dout_o = '0;
        if (rd_state && (cnt_q < n_q)) begin
            bus.ram_a_o = addr_q + ADDR_W'(cnt_q);
        end else if ((state_q == ST_MEM_WR) && (cnt_q < n_q)) begin
            bus.ram_a_o    = addr_q + ADDR_W'(cnt_q);
            bus.ram_wr_o   = RAM_WRITE;
            bus.ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: BYTE_W];
        end
    end

    assign bus.if_data_o  = if_data_q;
    assign bus.if_done_o  = if_done_q;
    assign bus.mem_data_o = mem_data_q;
    assign bus.mem_done_o = mem_done_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM model, shadow memory for
// expected data, and an expected-data queue popped on each done pulse.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk;
  logic rst;
  mem_ctrl_if bus();

  mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_if_data = '0;
  logic [7:0] ram_model [logic [31:0]];
  logic [7:0] shadow    [logic [31:0]];
  int wr_count = 0;
  int both_done = 0;

  // RAM with one-cycle read latency; writes land on the edge ending the write cycle.
  always @(posedge clk) begin
    if (bus.ram_wr_o === 1'b1) begin
      ram_model[bus.ram_a_o] = bus.ram_dout_o;
      wr_count++;
    end
    bus.ram_din_i <= ram_model.exists(bus.ram_a_o) ? ram_model[bus.ram_a_o] : 8'h00;
  end

  always @(negedge clk) begin
    if (bus.if_done_o === 1'b1 && bus.mem_done_o === 1'b1) both_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.if_cancel_i = 1'b0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
    bus.mem_len_i   = '0;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram_model[a] = b;
    shadow[a]    = b;
  endtask

  function automatic logic [31:0] shadow_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    logic [31:0] ak;
    w = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      w[8*k +: 8] = shadow.exists(ak) ? shadow[ak] : 8'h00;
    end
    return w;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] ak;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      ak = a + k;
      w[8*k +: 8] = ram_model.exists(ak) ? ram_model[ak] : 8'h00;
    end
    return w;
  endfunction

  task automatic drive_mem(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] len);
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = we;
    bus.mem_addr_i  = a;
    bus.mem_wdata_i = wd;
    bus.mem_len_i   = len;
  endtask

  // Returns the number of edges from the current cycle to the done pulse, -1 on timeout.
  task automatic wait_done(input bit is_if, input int budget, output int lat);
    lat = 0;
    while (((is_if ? bus.if_done_o : bus.mem_done_o) !== 1'b1) && (lat <= budget)) begin
      tick();
      lat++;
    end
    if (lat > budget) lat = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) tick();
    n_cmp++; if (bus.dbg_state !== ST_IDLE) begin n_mis++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    n_cmp++; if (bus.if_done_o !== 1'b0) begin n_mis++; $display("FAIL reset_if_done: got %b want 0", bus.if_done_o); end
    n_cmp++; if (bus.mem_done_o !== 1'b0) begin n_mis++; $display("FAIL reset_mem_done: got %b want 0", bus.mem_done_o); end
    n_cmp++; if (bus.if_data_o !== 32'h0) begin n_mis++; $display("FAIL reset_if_data: got %h want 0", bus.if_data_o); end
    n_cmp++; if (bus.mem_data_o !== 32'h0) begin n_mis++; $display("FAIL reset_mem_data: got %h want 0", bus.mem_data_o); end
    n_cmp++; if ({bus.ram_a_o, bus.ram_wr_o, bus.ram_dout_o} !== 41'h0) begin n_mis++; $display("FAIL reset_ram: got a=%h wr=%b d=%h want 0", bus.ram_a_o, bus.ram_wr_o, bus.ram_dout_o); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    logic [31:0] e;
    preload(32'h100, 8'h13); preload(32'h101, 8'h00); preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    exp_q.push_back(shadow_word(32'h100, 4));
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    tick();  // E0
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = 32'hDEAD_0000;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.ram_a_o !== 32'h100 + k || bus.ram_wr_o !== 1'b0) begin n_mis++; $display("FAIL fetch_addr[%0d]: got a=%h wr=%b want a=%h wr=0", k, bus.ram_a_o, bus.ram_wr_o, 32'h100 + k); end
      tick();
    end
    n_cmp++; if (bus.if_done_o !== 1'b0) begin n_mis++; $display("FAIL fetch_done_early: got %b want 0 at E4", bus.if_done_o); end
    tick();  // E5
    e = exp_q.pop_front();
    n_cmp++; if (bus.if_done_o !== 1'b1) begin n_mis++; $display("FAIL fetch_done_e5: got %b want 1", bus.if_done_o); end
    n_cmp++; if (bus.if_data_o !== e || e !== 32'h0000_0013) begin n_mis++; $display("FAIL fetch_data: got %h want %h", bus.if_data_o, e); end
    last_if_data = e;
    tick();
    n_cmp++; if (bus.if_done_o !== 1'b0 || bus.if_data_o !== last_if_data) begin n_mis++; $display("FAIL fetch_pulse_hold: got done=%b data=%h want done=0 data=%h", bus.if_done_o, bus.if_data_o, last_if_data); end
  endtask

  task automatic test_priority();
    logic [31:0] e;
    int lat;
    preload(32'h1000, 8'hAB); preload(32'h1001, 8'hCD);
    preload(32'h0, 8'h11); preload(32'h1, 8'h22); preload(32'h2, 8'h33); preload(32'h3, 8'h44);
    exp_q.push_back(shadow_word(32'h1000, 2));
    exp_q.push_back(shadow_word(32'h0, 4));
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0;
    drive_mem(1'b0, 32'h1000, 32'h0, LEN_2);
    tick();  // E0
    n_cmp++; if (bus.dbg_state !== ST_MEM_RD || bus.ram_a_o !== 32'h1000) begin n_mis++; $display("FAIL prio_mem_first: got st=%0d a=%h want st=%0d a=00001000", bus.dbg_state, bus.ram_a_o, ST_MEM_RD); end
    tick();  // E1
    n_cmp++; if (bus.ram_a_o !== 32'h1001) begin n_mis++; $display("FAIL prio_addr1: got %h want 00001001", bus.ram_a_o); end
    tick();  // E2
    tick();  // E3
    e = exp_q.pop_front();
    n_cmp++; if (bus.mem_done_o !== 1'b1 || bus.mem_data_o !== e || e !== 32'h0000_CDAB) begin n_mis++; $display("FAIL prio_load: got done=%b data=%h want done=1 data=%h", bus.mem_done_o, bus.mem_data_o, e); end
    n_cmp++; if (bus.dbg_state !== ST_IDLE || bus.if_done_o !== 1'b0) begin n_mis++; $display("FAIL prio_e3_idle: got st=%0d if_done=%b want st=0 if_done=0", bus.dbg_state, bus.if_done_o); end
    tick();  // E4: held mem request blocked, fetch accepted
    n_cmp++; if (bus.dbg_state !== ST_IF_RD || bus.mem_done_o !== 1'b0) begin n_mis++; $display("FAIL prio_fetch_e4: got st=%0d mem_done=%b want st=%0d mem_done=0", bus.dbg_state, bus.mem_done_o, ST_IF_RD); end
    idle_inputs();
    wait_done(1'b1, 10, lat);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 5) begin n_mis++; $display("FAIL prio_fetch_lat: got %0d want 5", lat); end
    n_cmp++; if (bus.if_data_o !== e) begin n_mis++; $display("FAIL prio_fetch_data: got %h want %h", bus.if_data_o, e); end
    last_if_data = e;
    tick();
  endtask

  task automatic test_store();
    int wr0;
    preload(32'h20, 8'h00); preload(32'h21, 8'h5A);
    wr0 = wr_count;
    drive_mem(1'b1, 32'h20, 32'hDEAD_BEEF, LEN_1);
    shadow[32'h20] = 8'hEF;
    tick();  // E0
    idle_inputs();
    n_cmp++; if (bus.ram_wr_o !== 1'b1 || bus.ram_a_o !== 32'h20 || bus.ram_dout_o !== 8'hEF) begin n_mis++; $display("FAIL store_bus: got wr=%b a=%h d=%h want wr=1 a=00000020 d=ef", bus.ram_wr_o, bus.ram_a_o, bus.ram_dout_o); end
    n_cmp++; if (bus.mem_done_o !== 1'b0) begin n_mis++; $display("FAIL store_done_early: got %b want 0", bus.mem_done_o); end
    tick();  // E1
    n_cmp++; if (bus.mem_done_o !== 1'b1 || bus.ram_wr_o !== 1'b0 || bus.dbg_state !== ST_IDLE) begin n_mis++; $display("FAIL store_done_e1: got done=%b wr=%b st=%0d want 1/0/0", bus.mem_done_o, bus.ram_wr_o, bus.dbg_state); end
    tick();
    n_cmp++; if (bus.mem_done_o !== 1'b0) begin n_mis++; $display("FAIL store_pulse: got %b want 0", bus.mem_done_o); end
    n_cmp++; if (wr_count - wr0 !== 1 || ram_model[32'h20] !== 8'hEF || ram_model[32'h21] !== 8'h5A) begin n_mis++; $display("FAIL store_ram: got writes=%0d m20=%h m21=%h want 1/ef/5a", wr_count - wr0, ram_model[32'h20], ram_model[32'h21]); end
  endtask

  task automatic test_cancel();
    logic [31:0] e;
    int lat;
    for (int k = 0; k < 4; k++) begin
      preload(32'h200 + k, 8'(k + 1));
      preload(32'h300 + k, 8'(8'hA0 + k));
    end
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h200;
    tick();  // E0
    bus.if_req_i = 1'b0;
    tick();  // E1
    tick();  // E2
    bus.if_cancel_i = 1'b1;
    tick();  // E3
    n_cmp++; if (bus.dbg_state !== ST_IDLE || bus.if_done_o !== 1'b0 || bus.if_data_o !== last_if_data) begin n_mis++; $display("FAIL cancel_e3: got st=%0d done=%b data=%h want 0/0/%h", bus.dbg_state, bus.if_done_o, bus.if_data_o, last_if_data); end
    bus.if_cancel_i = 1'b0;
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h300;
    exp_q.push_back(shadow_word(32'h300, 4));
    tick();  // E0 of the new fetch
    n_cmp++; if (bus.dbg_state !== ST_IF_RD || bus.ram_a_o !== 32'h300) begin n_mis++; $display("FAIL cancel_refetch: got st=%0d a=%h want st=%0d a=00000300", bus.dbg_state, bus.ram_a_o, ST_IF_RD); end
    bus.if_req_i = 1'b0;
    wait_done(1'b1, 10, lat);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 5 || bus.if_data_o !== e) begin n_mis++; $display("FAIL cancel_refetch_data: got lat=%0d data=%h want lat=5 data=%h", lat, bus.if_data_o, e); end
    last_if_data = e;
    tick();
    // Cancel while idle blocks the fetch request.
    bus.if_cancel_i = 1'b1;
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h200;
    tick();
    n_cmp++; if (bus.dbg_state !== ST_IDLE) begin n_mis++; $display("FAIL cancel_idle_block: got st=%0d want 0", bus.dbg_state); end
    idle_inputs();
    // Cancel has no effect on a load.
    exp_q.push_back(shadow_word(32'h300, 4));
    drive_mem(1'b0, 32'h300, 32'h0, LEN_4);
    tick();
    idle_inputs();
    bus.if_cancel_i = 1'b1;
    wait_done(1'b0, 10, lat);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 5 || bus.mem_data_o !== e) begin n_mis++; $display("FAIL cancel_ignored_load: got lat=%0d data=%h want lat=5 data=%h", lat, bus.mem_data_o, e); end
    bus.if_cancel_i = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] want_a [4];
    logic [31:0] e;
    want_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    preload(32'hFFFF_FFFE, 8'h01); preload(32'hFFFF_FFFF, 8'h02);
    exp_q.push_back(shadow_word(32'hFFFF_FFFE, 4));
    drive_mem(1'b0, 32'hFFFF_FFFE, 32'h0, LEN_4);
    tick();  // E0
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.ram_a_o !== want_a[k]) begin n_mis++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, bus.ram_a_o, want_a[k]); end
      tick();
    end
    tick();  // E5
    e = exp_q.pop_front();
    n_cmp++; if (bus.mem_done_o !== 1'b1 || bus.mem_data_o !== e || e !== 32'h2211_0201) begin n_mis++; $display("FAIL wrap_data: got done=%b data=%h want done=1 data=%h", bus.mem_done_o, bus.mem_data_o, e); end
    tick();
  endtask

  task automatic test_reset_mid();
    int wr0;
    int lat;
    wr0 = wr_count;
    drive_mem(1'b1, 32'h40, 32'h1234_5678, LEN_4);
    tick();  // E0
    idle_inputs();
    tick();  // E1
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.ram_wr_o !== 1'b0 || bus.ram_a_o !== 32'h0 || bus.dbg_state !== ST_IDLE) begin n_mis++; $display("FAIL rstmid_immediate: got wr=%b a=%h st=%0d want 0/0/0", bus.ram_wr_o, bus.ram_a_o, bus.dbg_state); end
    tick();
    tick();
    n_cmp++; if (bus.mem_done_o !== 1'b0 || wr_count - wr0 !== 1) begin n_mis++; $display("FAIL rstmid_abandon: got done=%b writes=%0d want done=0 writes=1", bus.mem_done_o, wr_count - wr0); end
    last_if_data = '0;
    rst = 1'b1;
    drive_mem(1'b1, 32'h40, 32'h1234_5678, LEN_4);
    for (int k = 0; k < 4; k++) shadow[32'h40 + k] = 8'(32'h1234_5678 >> (8 * k));
    tick();  // first edge with rst high
    n_cmp++; if (bus.dbg_state !== ST_MEM_WR) begin n_mis++; $display("FAIL rstmid_accept: got st=%0d want %0d", bus.dbg_state, ST_MEM_WR); end
    idle_inputs();
    wait_done(1'b0, 10, lat);
    n_cmp++; if (lat !== 4) begin n_mis++; $display("FAIL rstmid_store_lat: got %0d want 4", lat); end
    tick();
    n_cmp++; if (ram_word(32'h40) !== 32'h1234_5678) begin n_mis++; $display("FAIL rstmid_store_ram: got %h want 12345678", ram_word(32'h40)); end
  endtask

  task automatic test_back_to_back();
    logic        we;
    logic [31:0] a, wd, e;
    logic [2:0]  len;
    int          n, lat, diffs;
    for (int i = 0; i < 16; i++) begin
      we  = 1'($urandom_range(0, 1));
      a   = 32'h800 + $urandom_range(0, 12);
      len = 3'($urandom_range(0, 7));
      wd  = $urandom;
      n   = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
      if (we) begin
        for (int k = 0; k < n; k++) shadow[a + k] = wd[8*k +: 8];
      end else begin
        exp_q.push_back(shadow_word(a, n));
      end
      drive_mem(we, a, wd, len);
      tick();
      idle_inputs();
      wait_done(1'b0, 10, lat);
      n_cmp++; if (lat !== (we ? n : n + 1)) begin n_mis++; $display("FAIL b2b_lat[%0d]: got %0d want %0d (we=%b len=%0d)", i, lat, we ? n : n + 1, we, len); end
      if (!we) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.mem_data_o !== e) begin n_mis++; $display("FAIL b2b_load[%0d]: got %h want %h (a=%h len=%0d)", i, bus.mem_data_o, e, a, len); end
      end
      tick();
    end
    diffs = 0;
    for (int k = 0; k < 16; k++) begin
      if ((shadow.exists(32'h800 + k) ? shadow[32'h800 + k] : 8'h00) !==
          (ram_model.exists(32'h800 + k) ? ram_model[32'h800 + k] : 8'h00)) diffs++;
    end
    n_cmp++; if (diffs !== 0) begin n_mis++; $display("FAIL b2b_ram_image: got %0d differing bytes want 0", diffs); end
  endtask

  task automatic test_invariants();
    n_cmp++; if (both_done !== 0) begin n_mis++; $display("FAIL both_done: got %0d cycles want 0", both_done); end
    n_cmp++; if (exp_q.size() !== 0) begin n_mis++; $display("FAIL exp_q_drain: got %0d left want 0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_cancel();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
